// File: rtl/uart_word_packer_if.sv
// Byte-in / word-out interface for uart_word_packer.
// The master modport drives bytes in and consumes words; the slave modport is the packer side.
interface uart_word_packer_if #(
  parameter int BYTES_PER_WORD = 2,
  parameter int FIFO_DEPTH     = 4
);
  localparam int W     = 8 * BYTES_PER_WORD;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             uart_byte_ready;
  logic [7:0]       uart_byte;
  logic             flush;
  logic             word_ready;
  logic             word_valid;
  logic [W-1:0]     uart_word;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic             timeout_flush;

  modport master (
    output uart_byte_ready, uart_byte, flush, word_ready,
    input  word_valid, uart_word, fifo_count, overflow, timeout_flush
  );

  modport slave (
    input  uart_byte_ready, uart_byte, flush, word_ready,
    output word_valid, uart_word, fifo_count, overflow, timeout_flush
  );
endinterface

// File: rtl/uart_word_packer.sv
// Packs UART bytes into BYTES_PER_WORD-byte words and buffers them in a FWFT FIFO.
// Optional partial-word idle timeout is enabled by defining UART_PACKER_TIMEOUT_EN.
module uart_word_packer #(
  parameter int BYTES_PER_WORD = 2,
  parameter int MSB_FIRST      = 1,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  uart_word_packer_if.slave   bus
);
  localparam int W     = 8 * BYTES_PER_WORD;
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAST  = BYTES_PER_WORD - 1;

  typedef enum logic {IDLE, ASSEMBLE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     part_q;
  logic [W-1:0]     merged;
  logic [IDX_W-1:0] lane;
  logic             accept, last_byte, push, expire;

  assign accept    = bus.uart_byte_ready && !bus.flush;
  assign last_byte = (BYTES_PER_WORD == 1) ||
                     ((state_q == ASSEMBLE) && (idx_q == IDX_W'(LAST)));
  assign push      = accept && last_byte;
  assign lane      = (MSB_FIRST != 0) ? IDX_W'(LAST) - idx_q : idx_q;

  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    merged = part_q;
    merged[int'(lane)*8 +: 8] = bus.uart_byte;
  end

  // Flush beats a same-cycle strobe; an accepted strobe beats the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      part_q  <= '0;
    end else if (bus.flush || expire) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else if (accept) begin
      part_q <= merged;
      if (last_byte) begin
        state_q <= IDLE;
        idx_q   <= '0;
      end else begin
        state_q <= ASSEMBLE;
        idx_q   <= idx_q + 1'b1;
      end
    end
  end

`ifdef UART_PACKER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] idle_q;
  logic             tmo_q;

  assign expire = (state_q == ASSEMBLE) && !bus.uart_byte_ready && !bus.flush &&
                  (idle_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tmo_q <= expire;
      if ((state_q != ASSEMBLE) || bus.uart_byte_ready || bus.flush || expire)
        idle_q <= '0;
      else
        idle_q <= idle_q + 1'b1;
    end
  end

  assign bus.timeout_flush = tmo_q;
`else
  assign expire            = 1'b0;
  assign bus.timeout_flush = 1'b0;
`endif

  logic [W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q;
  logic             full, pop, wr_en;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop   = (count_q != '0) && bus.word_ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
  end

  // NOTE: storage is not reset; the output mux hides stale entries while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign bus.word_valid = (count_q != '0);
  assign bus.uart_word  = bus.word_valid ? mem[rd_ptr_q] : '0;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = ovf_q;
endmodule
